io_bus_initiator: RTL and testbench

IO_BUS_INITIATOR -- requirements
Module: io_bus_initiator

---
 rtl/io_bus_pkg.sv | 44 ++++
 rtl/io_timeout_counter.sv | 29 ++
 rtl/io_bus_initiator.sv | 148 ++++++++++++++
 tb/tb_io_bus_initiator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus initiator.
// Command word layout, GPIO opcodes and FSM state encoding.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RESP,
    WRITEBACK
  } state_t;

  localparam logic [2:0] WriteBit   = 3'd0;
  localparam logic [2:0] SetBit     = 3'd1;
  localparam logic [2:0] ClearBit   = 3'd2;
  localparam logic [2:0] ReadStatus = 3'd3;
  localparam logic [2:0] ToggleBit  = 3'd4;
  localparam logic [2:0] ReadBit    = 3'd5;
  localparam logic [2:0] ConfigDir  = 3'd6;
  localparam logic [2:0] PulseBit   = 3'd7;

  localparam int AddrMsb = 15;
  localparam int AddrLsb = 13;
  localparam int OpMsb   = 12;
  localparam int OpLsb   = 10;
  localparam int PayMsb  = 9;
  localparam int PayLsb  = 0;

  localparam logic [15:0] TimeoutData = 16'hFFFF;

  typedef struct packed {
    logic [3:0]  dest;
    logic [15:0] data;
    logic        err;
  } wb_t;

  function automatic logic [2:0] cmdOpcode(input logic [15:0] cmd);
    return cmd[OpMsb:OpLsb];
  endfunction

  function automatic logic [2:0] cmdAddr(input logic [15:0] cmd);
    return cmd[AddrMsb:AddrLsb];
  endfunction

endpackage

// File: rtl/io_timeout_counter.sv
// Cycle counter for outstanding bus commands.
// termCount flags the last permitted busy cycle.
module io_timeout_counter #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic async_rst_n,
  input  logic clear,
  input  logic enable,
  output logic termCount
);

  localparam logic [7:0] Last = 8'(LIMIT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign termCount = (count == Last);

endmodule

// File: rtl/io_bus_initiator.sv
// Single-outstanding IO bus initiator with timeout abort
// and register-file writeback of responder data.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        async_rst_n,
  input  logic        clk_en,
  input  logic        Cmd_Valid,
  output logic        Cmd_Ready,
  input  logic [15:0] Cmd_Data,
  input  logic [3:0]  Cmd_DestReg,
  input  logic        Cmd_ResponseRequested,
  output logic        IO_REQ,
  output logic        IO_CommandEn,
  output logic        IO_ResponseRequested,
  output logic [3:0]  IO_DestRegOut,
  output logic [15:0] IO_DataOut,
  input  logic        IO_ACK,
  input  logic        IO_CommandResponse,
  input  logic        IO_RegResponseFlag,
  input  logic        IO_MemResponseFlag,
  input  logic [3:0]  IO_DestRegIn,
  input  logic [15:0] IO_DataIn,
  output logic        WB_Valid,
  input  logic        WB_Ready,
  output logic [3:0]  WB_DestReg,
  output logic [15:0] WB_Data,
  output logic        WB_Error,
  output logic        Timeout_Flag,
  input  logic        Clear_Err
);

  state_t state, stateNext;

  logic [15:0] cmdQ;
  logic [3:0]  destQ;
  logic        respReqQ;
  wb_t         wbQ, wbNext;
  logic        wbLoad;
  logic        flagQ;

  logic accept, busy, respIn, wantWb;
  logic termCount, timeout;
  logic unusedMem;

  // Memory responses never produce a writeback.
  assign unusedMem = IO_MemResponseFlag;

  assign accept = Cmd_Ready && Cmd_Valid;
  assign busy   = (state == ISSUE) || (state == WAIT_RESP);
  assign wantWb = IO_RegResponseFlag && respReqQ;

  assign respIn =
    ((state == ISSUE) && IO_ACK && IO_CommandResponse) ||
    ((state == WAIT_RESP) && IO_CommandResponse);

  assign timeout = busy && termCount && !respIn;

  io_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) uTimeout (
    .clk        (clk),
    .async_rst_n(async_rst_n),
    .clear      (accept),
    .enable     (clk_en && busy),
    .termCount  (termCount)
  );

  always_comb begin
    stateNext = state;
    wbLoad    = 1'b0;
    wbNext    = wbQ;
    if (clk_en) begin
      unique case (state)
        IDLE: begin
          if (accept) stateNext = ISSUE;
        end
        ISSUE, WAIT_RESP: begin
          if (respIn) begin
            stateNext = wantWb ? WRITEBACK : IDLE;
            wbLoad    = wantWb;
            wbNext    = '{dest: IO_DestRegIn,
                          data: IO_DataIn,
                          err:  1'b0};
          end else if (termCount) begin
            stateNext = respReqQ ? WRITEBACK : IDLE;
            wbLoad    = respReqQ;
            wbNext    = '{dest: destQ,
                          data: TimeoutData,
                          err:  1'b1};
          end else if ((state == ISSUE) && IO_ACK) begin
            stateNext = WAIT_RESP;
          end
        end
        WRITEBACK: begin
          if (WB_Ready) stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      cmdQ     <= '0;
      destQ    <= '0;
      respReqQ <= 1'b0;
      wbQ      <= '0;
      flagQ    <= 1'b0;
    end else begin
      if (accept) begin
        cmdQ     <= Cmd_Data;
        destQ    <= Cmd_DestReg;
        respReqQ <= Cmd_ResponseRequested;
      end
      if (wbLoad) wbQ <= wbNext;
      // A fresh timeout outranks a pending clear.
      if (clk_en) begin
        if (timeout) flagQ <= 1'b1;
        else if (Clear_Err) flagQ <= 1'b0;
      end
    end
  end

  assign Cmd_Ready            = (state == IDLE) && clk_en;
  assign IO_REQ               = (state == ISSUE);
  assign IO_CommandEn         = (state == ISSUE);
  assign IO_ResponseRequested = (state == ISSUE) && respReqQ;
  assign IO_DestRegOut        = destQ;
  assign IO_DataOut           = cmdQ;
  assign WB_Valid             = (state == WRITEBACK);
  assign WB_DestReg           = wbQ.dest;
  assign WB_Data              = wbQ.data;
  assign WB_Error             = wbQ.err;
  assign Timeout_Flag         = flagQ;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Directed bench for io_bus_initiator.
// Table of transactions plus reset and clear sequences.
module tb_io_bus_initiator;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [15:0] Cmd_Data;
  logic [3:0]  Cmd_DestReg;
  logic        Cmd_ResponseRequested;
  logic        IO_REQ;
  logic        IO_CommandEn;
  logic        IO_ResponseRequested;
  logic [3:0]  IO_DestRegOut;
  logic [15:0] IO_DataOut;
  logic        IO_ACK;
  logic        IO_CommandResponse;
  logic        IO_RegResponseFlag;
  logic        IO_MemResponseFlag;
  logic [3:0]  IO_DestRegIn;
  logic [15:0] IO_DataIn;
  logic        WB_Valid;
  logic        WB_Ready;
  logic [3:0]  WB_DestReg;
  logic [15:0] WB_Data;
  logic        WB_Error;
  logic        Timeout_Flag;
  logic        Clear_Err;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  io_bus_initiator #(
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk                  (clk),
    .async_rst_n          (async_rst_n),
    .clk_en               (clk_en),
    .Cmd_Valid            (Cmd_Valid),
    .Cmd_Ready            (Cmd_Ready),
    .Cmd_Data             (Cmd_Data),
    .Cmd_DestReg          (Cmd_DestReg),
    .Cmd_ResponseRequested(Cmd_ResponseRequested),
    .IO_REQ               (IO_REQ),
    .IO_CommandEn         (IO_CommandEn),
    .IO_ResponseRequested (IO_ResponseRequested),
    .IO_DestRegOut        (IO_DestRegOut),
    .IO_DataOut           (IO_DataOut),
    .IO_ACK               (IO_ACK),
    .IO_CommandResponse   (IO_CommandResponse),
    .IO_RegResponseFlag   (IO_RegResponseFlag),
    .IO_MemResponseFlag   (IO_MemResponseFlag),
    .IO_DestRegIn         (IO_DestRegIn),
    .IO_DataIn            (IO_DataIn),
    .WB_Valid             (WB_Valid),
    .WB_Ready             (WB_Ready),
    .WB_DestReg           (WB_DestReg),
    .WB_Data              (WB_Data),
    .WB_Error             (WB_Error),
    .Timeout_Flag         (Timeout_Flag),
    .Clear_Err            (Clear_Err)
  );

  typedef struct {
    logic [15:0] cmd;
    logic [3:0]  dest;
    logic        req;
    int          ack;
    int          resp;
    logic        regF;
    logic        memF;
    logic [15:0] rdata;
    logic [3:0]  rdest;
    int          hold;
    int          freeze;
    logic        clr;
    int          expWb;
    int          expIdle;
    int          expReqLow;
    logic [15:0] expData;
    logic [3:0]  expDest;
    logic        expErr;
    logic        expFlag;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic clearBus();
    IO_ACK             = 1'b0;
    IO_CommandResponse = 1'b0;
    IO_RegResponseFlag = 1'b0;
    IO_MemResponseFlag = 1'b0;
    clk_en             = 1'b1;
    WB_Ready           = 1'b1;
    Clear_Err          = 1'b0;
    Cmd_Valid          = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle; ends at the idle negedge.
  task automatic runVec(input vec_t v, input int idx);
    int wbK     = 0;
    int idleK   = 0;
    int reqLowK = 0;
    int holdCnt = 0;
    logic [15:0] capData = '0;
    logic [3:0]  capDest = '0;
    logic        capErr  = 1'b0;
    string nm = $sformatf("v%0d", idx);

    chk({nm, " ready"}, 32'(Cmd_Ready), 32'd1);
    Cmd_Valid             = 1'b1;
    Cmd_Data              = v.cmd;
    Cmd_DestReg           = v.dest;
    Cmd_ResponseRequested = v.req;
    Clear_Err             = v.clr;
    IO_DataIn             = v.rdata;
    IO_DestRegIn          = v.rdest;
    @(negedge clk);
    Cmd_Valid = 1'b0;
    Cmd_Data  = ~v.cmd;

    for (int k = 1; k <= 40; k++) begin
      if (k == 1)
        chk({nm, " issue"},
            32'({IO_REQ, IO_CommandEn, IO_ResponseRequested,
                 IO_DestRegOut, IO_DataOut}),
            32'({2'b11, v.req, v.dest, v.cmd}));
      if (!IO_REQ && reqLowK == 0) reqLowK = k;
      if (WB_Valid) begin
        if (wbK == 0) begin
          wbK     = k;
          capData = WB_Data;
          capDest = WB_DestReg;
          capErr  = WB_Error;
        end else begin
          chk({nm, " stall"},
              32'({WB_DestReg, WB_Data, WB_Error, Cmd_Ready}),
              32'({capDest, capData, capErr, 1'b0}));
        end
        if (holdCnt < v.hold) begin
          WB_Ready  = 1'b0;
          Cmd_Valid = 1'b1;
          Cmd_Data  = 16'hDEAD;
          holdCnt++;
        end else begin
          WB_Ready  = 1'b1;
          Cmd_Valid = 1'b0;
        end
      end
      if (Cmd_Ready) begin
        idleK = k;
        break;
      end
      clk_en = !(v.freeze != 0 && k >= v.freeze &&
                 k < v.freeze + 3);
      IO_ACK             = (k == v.ack);
      IO_CommandResponse = (k == v.resp);
      IO_RegResponseFlag = (k == v.resp) && v.regF;
      IO_MemResponseFlag = (k == v.resp) && v.memF;
      @(negedge clk);
    end
    clearBus();

    chk({nm, " wbCycle"}, 32'(wbK), 32'(v.expWb));
    chk({nm, " idleCycle"}, 32'(idleK), 32'(v.expIdle));
    chk({nm, " reqLow"}, 32'(reqLowK), 32'(v.expReqLow));
    chk({nm, " flag"}, 32'(Timeout_Flag), 32'(v.expFlag));
    chk({nm, " dataOut"}, 32'(IO_DataOut), 32'(v.cmd));
    if (v.expWb != 0)
      chk({nm, " payload"},
          32'({capDest, capData, capErr}),
          32'({v.expDest, v.expData, v.expErr}));
  endtask

  initial begin
    // cmd dest req ack resp reg mem rdata rdest hold frz clr
    // wb idle reqLow data dest err flag
    vecs[0] = '{16'h2C01, 4'h5, 1'b1, 1, 1, 1'b1, 1'b0,
                16'h0001, 4'h5, 0, 0, 1'b0,
                2, 3, 2, 16'h0001, 4'h5, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 4'h2, 1'b0, 1, 1, 1'b0, 1'b0,
                16'h0000, 4'h0, 0, 0, 1'b0,
                0, 2, 2, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[2] = '{16'h3401, 4'h7, 1'b1, 1, 1, 1'b0, 1'b1,
                16'hBEEF, 4'h7, 0, 0, 1'b0,
                0, 2, 2, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[3] = '{16'h4C02, 4'h3, 1'b0, 1, 1, 1'b1, 1'b0,
                16'h1234, 4'h3, 0, 0, 1'b0,
                0, 2, 2, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[4] = '{16'h6C05, 4'h9, 1'b1, 3, 6, 1'b1, 1'b0,
                16'hA5A5, 4'h9, 4, 0, 1'b0,
                7, 12, 4, 16'hA5A5, 4'h9, 1'b0, 1'b0};
    vecs[5] = '{16'h8C00, 4'hA, 1'b1, 2, 15, 1'b1, 1'b0,
                16'h5A5A, 4'hA, 0, 0, 1'b0,
                16, 17, 3, 16'h5A5A, 4'hA, 1'b0, 1'b0};
    vecs[6] = '{16'hAC00, 4'hC, 1'b1, 0, 0, 1'b0, 1'b0,
                16'h0000, 4'h0, 0, 0, 1'b0,
                16, 17, 16, 16'hFFFF, 4'hC, 1'b1, 1'b1};
    vecs[7] = '{16'h1C03, 4'h4, 1'b0, 0, 0, 1'b0, 1'b0,
                16'h0000, 4'h0, 0, 0, 1'b1,
                0, 16, 16, 16'h0000, 4'h0, 1'b0, 1'b1};
    vecs[8] = '{16'hE001, 4'h6, 1'b1, 1, 0, 1'b0, 1'b0,
                16'h0000, 4'h0, 0, 0, 1'b0,
                16, 17, 2, 16'hFFFF, 4'h6, 1'b1, 1'b1};
    vecs[9] = '{16'h2C07, 4'hB, 1'b1, 0, 0, 1'b0, 1'b0,
                16'h0000, 4'h0, 0, 5, 1'b0,
                19, 20, 19, 16'hFFFF, 4'hB, 1'b1, 1'b1};

    async_rst_n           = 1'b0;
    Cmd_Data              = '0;
    Cmd_DestReg           = '0;
    Cmd_ResponseRequested = 1'b0;
    IO_DataIn             = '0;
    IO_DestRegIn          = '0;
    clearBus();

    #12;
    chk("resetOutputs",
        32'({IO_REQ, IO_CommandEn, IO_ResponseRequested,
             IO_DestRegOut, IO_DataOut, WB_Valid}),
        32'd0);
    chk("resetWb", 32'({WB_DestReg, WB_Data, WB_Error, Timeout_Flag}),
        32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) runVec(vecs[i], i);

    Clear_Err = 1'b1;
    @(negedge clk);
    Clear_Err = 1'b0;
    chk("clearErr", 32'(Timeout_Flag), 32'd0);

    for (int i = 7; i < 10; i++) runVec(vecs[i], i);

    // Reset pulse while waiting for a response.
    Cmd_Valid             = 1'b1;
    Cmd_Data              = 16'hFACE;
    Cmd_DestReg           = 4'hF;
    Cmd_ResponseRequested = 1'b1;
    @(negedge clk);
    Cmd_Valid = 1'b0;
    IO_ACK    = 1'b1;
    @(negedge clk);
    IO_ACK = 1'b0;
    chk("waitState", 32'({IO_REQ, IO_DataOut}),
        32'({1'b0, 16'hFACE}));
    #2 async_rst_n = 1'b0;
    #1;
    chk("midResetOut",
        32'({IO_REQ, IO_CommandEn, IO_ResponseRequested,
             IO_DestRegOut, IO_DataOut, WB_Valid}),
        32'd0);
    chk("midResetWb", 32'({WB_DestReg, WB_Data, WB_Error, Timeout_Flag}),
        32'd0);
    @(negedge clk);
    async_rst_n = 1'b1;
    @(negedge clk);
    runVec(vecs[0], 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
